imem_ctrl: RTL

IMEM_CTRL -- requirements
Module: imem_ctrl

---
 rtl/imem_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/imem_ctrl.sv
// Instruction memory controller: byte-serial program loader and word fetch port
// sharing one memory interface, arbitrated by a four-state FSM.
module imem_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_req,
  input  logic [DEPTH-1:0] f_addr,
  output logic             f_gnt,
  output logic             f_rvalid,
  output logic [WIDTH-1:0] f_rdata,
  output logic             f_misalign,
  input  logic             ld_start,
  input  logic [DEPTH-1:0] ld_base,
  input  logic [DEPTH-1:0] ld_len,
  input  logic             ld_valid,
  input  logic [7:0]       ld_byte,
  output logic             ld_ready,
  output logic             ld_done,
  output logic             busy,
  output logic [DEPTH-1:0] m_addr,
  output logic [WIDTH-1:0] m_wdata,
  output logic             m_wr,
  output logic             m_rd,
  input  logic [WIDTH-1:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD, FETCH, RESP} state_t;

  state_t           state, state_nxt;
  logic [DEPTH-1:0] ptr, cnt, faddr;
  logic             done_p1, mis_p1;
  logic             ld_acc, f_acc, byte_wr, last_byte, f_unaligned;

  // A load request wins over a fetch arriving in the same IDLE cycle.
  assign ld_acc      = (state == IDLE) && ld_start;
  assign f_acc       = (state == IDLE) && f_req && !ld_start;
  assign byte_wr     = (state == LOAD) && ld_valid;
  assign last_byte   = byte_wr && (cnt == DEPTH'(1));
  assign f_unaligned = (f_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ld_acc) begin
          if (ld_len != '0) state_nxt = LOAD;
        end else if (f_acc && !f_unaligned) begin
          state_nxt = FETCH;
        end
      end
      LOAD:    if (last_byte) state_nxt = IDLE;
      FETCH:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    f_gnt      = f_acc;
    f_rvalid   = (state == RESP);
    f_misalign = mis_p1;
    ld_ready   = (state == LOAD);
    ld_done    = done_p1;
    busy       = (state != IDLE);
    m_wr       = byte_wr;
    m_rd       = (state == FETCH);
    m_addr     = '0;
    m_wdata    = '0;
    if (byte_wr) begin
      m_addr  = ptr;
      m_wdata = {{(WIDTH-8){1'b0}}, ld_byte};
    end else if (state == FETCH) begin
      m_addr = faddr;
    end
  end

  // Completion pulses are suppressed by reset so an aborted operation reports nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_p1 <= 1'b0;
      mis_p1  <= 1'b0;
    end else begin
      done_p1 <= (ld_acc && (ld_len == '0)) || last_byte;
      mis_p1  <= f_acc && f_unaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      cnt     <= '0;
      faddr   <= '0;
      f_rdata <= '0;
    end else begin
      if (ld_acc) begin
        ptr <= ld_base;
        cnt <= ld_len;
      end else if (byte_wr) begin
        ptr <= ptr + DEPTH'(1);
        cnt <= cnt - DEPTH'(1);
      end
      if (f_acc) faddr <= f_addr;
      if (state == FETCH) f_rdata <= m_rdata;
    end
  end

endmodule
